// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: reads one 16-bit instruction as two bytes (low at PC, high at PC+1) into the IR.
// Optional per-byte wait-state timeout is compiled in when FETCH_TIMEOUT_EN is defined.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  PCLoad,
  input  logic [ADDR_WIDTH-1:0] PCIn,
  input  logic [7:0]            MemData,
  input  logic                  MemValid,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic [7:0]            IR_I,
  output logic                  IR_LH,
  output logic                  IR_Write,
  output logic [ADDR_WIDTH-1:0] PCOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  FetchErr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_LO = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] hi_addr;
  logic                  in_wait;
  logic                  timeout;

  assign in_wait = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign hi_addr = pc_q + ADDR_WIDTH'(1);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;

  assign timeout = in_wait && !MemValid && (wcnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts whenever the state changes; sticky error cleared by an accepted Start.
  always_comb begin
    wcnt_d = (state_d != state_q) ? {CW{1'b0}} : wcnt_q + CW'(1);
    if (timeout) begin
      err_d = 1'b1;
    end else if ((state_q == IDLE) && Start && !PCLoad) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wcnt_q <= {CW{1'b0}};
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign FetchErr = err_q;
`else
  assign timeout  = 1'b0;
  assign FetchErr = 1'b0;
`endif

  // Fetch sequencing and PC update; a timeout aborts to IDLE with the PC untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (PCLoad) begin
          pc_d = PCIn;
        end else if (Start) begin
          state_d = WAIT_LO;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        if (MemValid) begin
          state_d = WAIT_HI;
        end else begin
          state_d = WAIT_LO;
        end
      end
      WAIT_HI: begin
        if (MemValid) begin
          state_d = DONE;
          pc_d    = pc_q + ADDR_WIDTH'(2);
        end else begin
          state_d = WAIT_HI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    state_d = timeout ? IDLE : state_d;
  end

  // State and program counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // IR_I is gated so every output reads zero while reset is held.
  assign MemRead  = in_wait;
  assign MemAddr  = (state_q == WAIT_HI) ? hi_addr : pc_q;
  assign IR_I     = Reset ? MemData : 8'h00;
  assign IR_LH    = (state_q == WAIT_HI);
  assign IR_Write = in_wait && MemValid;
  assign PCOut    = pc_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a byte memory model feeds the DUT, expected
// instructions/PC/latency are queued at Start and checked by a monitor on every Done pulse.
module tb_instruction_fetch_unit;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       PCLoad;
  logic [7:0] PCIn;
  logic [7:0] MemData;
  logic       MemValid;
  logic [7:0] MemAddr;
  logic       MemRead;
  logic [7:0] IR_I;
  logic       IR_LH;
  logic       IR_Write;
  logic [7:0] PCOut;
  logic       Busy;
  logic       Done;
  logic       FetchErr;

  instruction_fetch_unit #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemData(MemData), .MemValid(MemValid), .MemAddr(MemAddr), .MemRead(MemRead),
    .IR_I(IR_I), .IR_LH(IR_LH), .IR_Write(IR_Write), .PCOut(PCOut), .Busy(Busy),
    .Done(Done), .FetchErr(FetchErr)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem [256];
  assign MemData = mem[MemAddr];

  typedef struct {
    logic [15:0] instr;
    int          pc;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pc_m = 0;
  logic [15:0] ir_m;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: models the IR register and checks every Done against the scoreboard
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      chk("ir_write_only_on_valid_read", IR_Write, MemRead & MemValid);
      if (IR_Write) begin
        if (IR_LH) ir_m[15:8] = IR_I;
        else       ir_m[7:0]  = IR_I;
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ir_value", ir_m, e.instr);
          chk("pc_after_done", PCOut, e.pc);
          chk("done_latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_pc(input int v, input bit with_start);
    logic [31:0] vv;
    vv = v;
    PCLoad = 1'b1; PCIn = vv[7:0]; Start = with_start;
    step();
    PCLoad = 1'b0; Start = 1'b0;
    pc_m = v % 256;
    chk("pcload_value", PCOut, pc_m);
    if (with_start) chk("pcload_drops_start", Busy, 0);
  endtask

  task automatic noise(input bit en);
    if (en) begin
      Start  = 1'($urandom % 2);
      PCLoad = 1'($urandom % 2);
      PCIn   = 8'($urandom);
    end else begin
      Start  = 1'b0;
      PCLoad = 1'b0;
    end
  endtask

  // Issues one fetch from IDLE with the given per-byte wait counts; the memory model answers
  task automatic fetch(input int wlo, input int whi, input bit busy_noise);
    exp_t e;
    e.instr = {mem[(pc_m + 1) % 256], mem[pc_m]};
    pc_m    = (pc_m + 2) % 256;
    e.pc    = pc_m;
    e.lat   = 3 + wlo + whi;
    e.t0    = cyc;
    exp_q.push_back(e);
    Start = 1'b1; PCLoad = 1'b0; MemValid = 1'b0;
    step();
    Start = 1'b0;
    repeat (wlo) begin noise(busy_noise); step(); end
    noise(1'b0); MemValid = 1'b1;
    step();
    MemValid = 1'b0;
    repeat (whi) begin noise(busy_noise); step(); end
    noise(1'b0); MemValid = 1'b1;
    step();
    noise(busy_noise); MemValid = 1'($urandom % 2);
    step();
    noise(1'b0); MemValid = 1'b0;
    chk("idle_after_fetch", Busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA5;
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    Reset = 1'b0; Start = 1'b1; PCLoad = 1'b0; PCIn = 8'h00; MemValid = 1'b1;

    // Outputs during reset, with Start/MemValid asserted and nonzero memory data
    step();
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_ir_i", IR_I, 0);
    chk("rst_ir_lh", IR_LH, 0);
    chk("rst_ir_write", IR_Write, 0);
    chk("rst_pcout", PCOut, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_fetcherr", FetchErr, 0);
    Start = 1'b0; MemValid = 1'b0;
    Reset = 1'b1;
    step();

    // Basic zero-wait fetch, then the same fetch with two waits per byte
    load_pc(8'h10, 1'b0);
    fetch(0, 0, 1'b0);
    load_pc(8'h10, 1'b0);
    fetch(2, 2, 1'b0);

    // High-byte address wraps at the top of memory
    load_pc(8'hFF, 1'b0);
    fetch(1, 0, 1'b0);
    chk("wrap_pc", PCOut, 8'h01);

    // Start with PCLoad in IDLE: load wins, no fetch; then Start/PCLoad noise while busy
    load_pc(8'h40, 1'b1);
    step();
    chk("no_fetch_after_load_start", Busy, 0);
    fetch(3, 3, 1'b1);

    // Reset while in WAIT_HI abandons the fetch
    Start = 1'b1; step(); Start = 1'b0;
    MemValid = 1'b1; step(); MemValid = 1'b0;
    step();
    chk("pre_reset_in_wait_hi", IR_LH, 1);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_memread", MemRead, 0);
    chk("midrst_pc", PCOut, 0);
    chk("midrst_done", Done, 0);
    step();
    Reset = 1'b1;
    pc_m = 0;
    repeat (4) step();
    chk("post_reset_idle", Busy, 0);

    // Randomized fetch mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 3 == 0) load_pc(int'($urandom % 256), 1'($urandom % 2));
      MemValid = 1'($urandom % 2);
      step();
      MemValid = 1'b0;
      chk("idle_ignores_memvalid", Busy, 0);
      fetch(int'($urandom % 4), int'($urandom % 4), 1'b1);
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      Start = 1'b1; step(); Start = 1'b0;
      n = 0;
      while (Busy && n < 100) begin step(); n++; end
      chk("timeout_cycles", n, 15);
      chk("timeout_err_set", FetchErr, 1);
      chk("timeout_pc_unchanged", PCOut, pc_m);
      fetch(0, 0, 1'b0);
      chk("timeout_err_cleared", FetchErr, 0);
    end
`else
    chk("fetcherr_tied_low", FetchErr, 0);
`endif

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
